// File: rtl/csa3_pkg.sv
// -----------------------------------------------------------------------------
// csa3_pkg
// Shared width helpers for the three-operand carry-save adder family.
// The MAC8 datapath reuses these so that all blocks agree on result widths.
//   sum_w(width)        : width of a full A+B+C result (width + 2)
//   acc_w(width, guard) : width of the running accumulator (sum_w + guard)
// -----------------------------------------------------------------------------
package csa3_pkg;

    // Three operands of at most 2^w-1 sum to less than 2^(w+2).
    function automatic int sum_w(input int width);
        return width + 2;
    endfunction

    function automatic int acc_w(input int width, input int guard);
        return sum_w(width) + guard;
    endfunction

endpackage

// File: rtl/csa3_row.sv
// -----------------------------------------------------------------------------
// csa3_row
// Purely combinational WIDTH-wide row of full adders that compresses three
// operands into a sum vector and a carry vector (carry-save form).
//   a, b, c : operand bits                    (in,  WIDTH)
//   s       : per-bit sum   a ^ b ^ c         (out, WIDTH)
//   cy      : per-bit carry maj(a, b, c)      (out, WIDTH), weight 2^(i+1)
// Also holds reversible_full_adder, the Peres-gate style cell the row uses.
// -----------------------------------------------------------------------------
module reversible_full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic p;

    // Peres structure: the propagate term is shared by sum and carry, and the
    // carry is formed with XOR so the cell maps onto a reversible gate pair.
    assign p  = a ^ b;
    assign s  = p ^ c;
    assign co = (a & b) ^ (p & c);
endmodule

module csa3_row #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] cy
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        reversible_full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .c  (c[i]),
            .s  (s[i]),
            .co (cy[i])
        );
    end
endmodule

// File: rtl/csa3_pipe_adder.sv
// -----------------------------------------------------------------------------
// csa3_pipe_adder
// Two-stage pipelined three-operand adder (A+B+C) with valid/ready on both
// sides. Stage 1 registers the carry-save sum/carry vectors, stage 2 registers
// the carry-propagate result. Up to two triples are in flight.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake; in_ready never looks at in_valid
//   a, b, c             : unsigned operands (WIDTH)
//   out_valid/out_ready : result handshake
//   sum                 : full-width result (WIDTH+2), never wraps
// Optional feature, macro CSA3_ACCUM_EN:
//   clear               : synchronous accumulator clear, wins over a transfer
//   acc_out             : running total of transferred sums (SUM_W+ACC_GUARD)
//   acc_ovf             : sticky carry-out of the accumulator
// -----------------------------------------------------------------------------
module csa3_pipe_adder
    import csa3_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int ACC_GUARD = 4,
    localparam int SUM_W    = sum_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum
`ifdef CSA3_ACCUM_EN
    ,
    input  logic                                 clear,
    output logic [acc_w(WIDTH, ACC_GUARD)-1:0]   acc_out,
    output logic                                 acc_ovf
`endif
);

    if (WIDTH < 2 || ACC_GUARD < 0) begin : g_param_check
        $error("csa3_pipe_adder: WIDTH must be >= 2 and ACC_GUARD >= 0");
    end

    // Carry-save row
    logic [WIDTH-1:0] row_s;
    logic [WIDTH-1:0] row_cy;

    csa3_row #(.WIDTH(WIDTH)) u_row (
        .a  (a),
        .b  (b),
        .c  (c),
        .s  (row_s),
        .cy (row_cy)
    );

    // Pipeline state
    logic             s1_valid_q,  s1_valid_d;
    logic [WIDTH-1:0] s1_s_q,      s1_s_d;
    logic [WIDTH:0]   s1_c_q,      s1_c_d;   // bit 0 is always zero
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] sum_q,       sum_d;

    logic s1_adv;
    logic s2_adv;
    logic accept;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        s2_adv      = !out_valid_q || out_ready;
        s1_adv      = !s1_valid_q || s2_adv;
        accept      = in_valid && s1_adv;

        s1_valid_d  = s1_valid_q;
        s1_s_d      = s1_s_q;
        s1_c_d      = s1_c_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;

        if (s1_adv) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_s_d = row_s;
            s1_c_d = {row_cy, 1'b0};    // carries move up one bit position
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            sum_d       = {2'b00, s1_s_q} + {1'b0, s1_c_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_s_q      <= '0;
            s1_c_q      <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before the edge, independent of statement order.
            s1_valid_q  <= s1_valid_d;
            s1_s_q      <= s1_s_d;
            s1_c_q      <= s1_c_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;

`ifdef CSA3_ACCUM_EN
    localparam int ACC_W = acc_w(WIDTH, ACC_GUARD);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [ACC_W:0]   acc_sum;
    logic             out_xfer;

    always_comb begin
        out_xfer  = out_valid_q && out_ready;
        acc_sum   = {1'b0, acc_q} + (ACC_W + 1)'(sum_q);
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;

        // Clear wins: a transfer in the same cycle is dropped from the total.
        if (clear) begin
            acc_d     = '0;
            acc_ovf_d = 1'b0;
        end else if (out_xfer) begin
            acc_d     = acc_sum[ACC_W-1:0];
            acc_ovf_d = acc_ovf_q || acc_sum[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

    assign acc_out = acc_q;
    assign acc_ovf = acc_ovf_q;
`endif

endmodule

// File: tb/tb_csa3_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_csa3_pipe_adder
// Scoreboard bench for csa3_pipe_adder (WIDTH=6). The driver pushes a+b+c for
// every accepted triple; an independent monitor pops and compares on every
// output transfer. Inputs change 1 time unit after the rising edge; handshake
// decisions and output sampling happen on the falling edge.
// With CSA3_ACCUM_EN defined the accumulator ports are connected and checked.
// -----------------------------------------------------------------------------
module tb_csa3_pipe_adder;

    localparam int WIDTH    = 6;
    localparam int SUM_W    = WIDTH + 2;
    localparam int TB_GUARD = 0;
    localparam int MAX_WAIT = 200;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic [WIDTH-1:0] c         = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [SUM_W-1:0] sum;
`ifdef CSA3_ACCUM_EN
    logic                      clear = 1'b0;
    logic [SUM_W+TB_GUARD-1:0] acc_out;
    logic                      acc_ovf;
`endif

    csa3_pipe_adder #(
        .WIDTH     (WIDTH),
        .ACC_GUARD (TB_GUARD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
`ifdef CSA3_ACCUM_EN
        ,
        .clear     (clear),
        .acc_out   (acc_out),
        .acc_ovf   (acc_ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_vec      = 0;
    int n_err      = 0;
    int n_accepted = 0;
    int n_stall    = 0;
    int exp_q[$];
    int mon_exp;
    bit rdy_random = 1'b0;
    bit rdy_level  = 1'b1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Downstream ready: random or a fixed level, updated just after each edge.
    always @(posedge clk) begin
        #1;
        out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_level;
    end

    // Monitor: a transfer happens at the next rising edge whenever valid and
    // ready are both high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got sum %0d, expected no output", sum);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sum", sum, mon_exp);
            end
        end
    end

    // Called 1 time unit after a rising edge; returns likewise after the
    // accepting edge.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic [WIDTH-1:0] tc);
        int waited = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        c = tc;
        @(negedge clk);
        while (!in_ready && waited < MAX_WAIT) begin
            n_stall++;
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1 within %0d cycles", MAX_WAIT);
        end else begin
            exp_q.push_back(int'(ta) + int'(tb) + int'(tc));
            n_accepted++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        // Reset values
        #7;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", in_ready, 1);

        // Basic triple and latency: accept edge is cycle 1, out_valid after cycle 2
        send(6'd5, 6'd9, 6'd3);
        check("latency_cycle1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_cycle2_out_valid", out_valid, 1);
        check("basic_sum", sum, 17);
        wait_drain();

        // Extremes
        send(6'd63, 6'd63, 6'd63);
        @(posedge clk);
        #1;
        check("max_sum", sum, 189);
        wait_drain();
        send(6'd0, 6'd0, 6'd0);
        @(posedge clk);
        #1;
        check("zero_sum", sum, 0);
        wait_drain();

        // Backpressure: only two triples fit while the output is stalled
        rdy_level = 1'b0;
        @(posedge clk);
        #1;
        n_accepted = 0;
        fork
            begin
                send(6'd1, 6'd1, 6'd1);
                send(6'd2, 6'd2, 6'd2);
                send(6'd3, 6'd3, 6'd3);
                send(6'd4, 6'd4, 6'd4);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_sum_hold", sum, 3);
                    check("stall_in_ready", in_ready, 0);
                end
                check("stall_accepted", n_accepted, 2);
                rdy_level = 1'b1;
            end
        join
        wait_drain();
        check("bp_accepted_total", n_accepted, 4);

        // Full throughput with out_ready held high: no stall cycles
        n_stall = 0;
        for (int i = 0; i < 20; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        end
        check("throughput_stalls", n_stall, 0);
        wait_drain();

        // Random stream with random downstream ready
        rdy_random = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        end
        rdy_random = 1'b0;
        rdy_level  = 1'b1;
        wait_drain();

        // Reset with two triples in flight discards them
        rdy_level = 1'b0;
        @(posedge clk);
        #1;
        send(6'd10, 6'd20, 6'd30);
        send(6'd40, 6'd50, 6'd60);
        check("pre_reset_out_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_sum", sum, 0);
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        rdy_level = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale_output", out_valid, 0);
        end
        @(posedge clk);
        #1;

`ifdef CSA3_ACCUM_EN
        begin
            int total;
            clear = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
            check("acc_cleared", acc_out, 0);
            check("acc_ovf_cleared", acc_ovf, 0);
            send(6'd63, 6'd63, 6'd63);
            send(6'd63, 6'd63, 6'd63);
            wait_drain();
            total = 2 * (63 + 63 + 63);
            check("acc_total", acc_out, total % (1 << (SUM_W + TB_GUARD)));
            check("acc_ovf_set", acc_ovf, (total >= (1 << (SUM_W + TB_GUARD))) ? 1 : 0);
            clear = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
            check("acc_clear_out", acc_out, 0);
            check("acc_clear_ovf", acc_ovf, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
